// File: rtl/binary_bbox_overlay.sv
// Bounding box of the foreground in a binary mask, latched once per frame at
// the vsync rising edge and drawn as a rectangle outline over the next frame.
module binary_bbox_overlay #(
  parameter int unsigned    DW      = 24,
  parameter int unsigned    XW      = 12,
  parameter int unsigned    CW      = 20,
  parameter int unsigned    MIN_PIX = 64,
  parameter logic [DW-1:0]  BOX_RGB = DW'(24'hFF0000)
) (
  input  logic          pixelclk,
  input  logic          reset,
  input  logic          i_x0,
  input  logic [DW-1:0] i_rgb,
  input  logic          i_hsync,
  input  logic          i_vsync,
  input  logic          i_de,
  output logic [DW-1:0] o_rgb,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_de,
  output logic [XW-1:0] o_xmin,
  output logic [XW-1:0] o_xmax,
  output logic [XW-1:0] o_ymin,
  output logic [XW-1:0] o_ymax,
  output logic [CW-1:0] o_pix_cnt,
  output logic          o_found,
  output logic          o_valid
);

  localparam logic [XW-1:0] XY_MAX  = '1;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] MIN_CNT = CW'(MIN_PIX);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;

  logic [0:0]    state, state_next;
  logic          vsync_d1, de_d1;
  logic [XW-1:0] x_cnt, y_cnt;
  logic [XW-1:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;
  logic [CW-1:0] acc_cnt;

  logic vs_rise_c, de_fall_c, fg_c;
  logic latch_c, clear_c, accum_c;
  logic on_box_c;

  assign vs_rise_c = i_vsync & ~vsync_d1;
  assign de_fall_c = de_d1 & ~i_de;
  assign fg_c      = i_de & i_x0;

  // State register
  always_ff @(posedge pixelclk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and frame-boundary actions; vs_rise wins over a coincident pixel
  always_comb begin
    state_next = state;
    latch_c    = 1'b0;
    clear_c    = 1'b0;
    accum_c    = 1'b0;
    case (state)
      IDLE: begin
        if (vs_rise_c) begin
          state_next = ACCUM;
          clear_c    = 1'b1;
        end
      end
      ACCUM: begin
        if (vs_rise_c) begin
          latch_c = 1'b1;
          clear_c = 1'b1;
        end else if (fg_c) begin
          accum_c = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pixel coordinate counters, saturating
  always_ff @(posedge pixelclk) begin
    if (reset) begin
      vsync_d1 <= 1'b0;
      de_d1    <= 1'b0;
      x_cnt    <= '0;
      y_cnt    <= '0;
    end else begin
      vsync_d1 <= i_vsync;
      de_d1    <= i_de;
      if (i_de) begin
        if (x_cnt != XY_MAX) x_cnt <= x_cnt + XW'(1);
      end else begin
        x_cnt <= '0;
      end
      if (vs_rise_c)                         y_cnt <= '0;
      else if (de_fall_c && y_cnt != XY_MAX) y_cnt <= y_cnt + XW'(1);
    end
  end

  // Running min/max and foreground count of the current frame
  always_ff @(posedge pixelclk) begin
    if (reset || clear_c) begin
      acc_xmin <= '1;
      acc_xmax <= '0;
      acc_ymin <= '1;
      acc_ymax <= '0;
      acc_cnt  <= '0;
    end else if (accum_c) begin
      if (x_cnt < acc_xmin) acc_xmin <= x_cnt;
      if (x_cnt > acc_xmax) acc_xmax <= x_cnt;
      if (y_cnt < acc_ymin) acc_ymin <= y_cnt;
      if (y_cnt > acc_ymax) acc_ymax <= y_cnt;
      if (acc_cnt != CNT_MAX) acc_cnt <= acc_cnt + CW'(1);
    end
  end

  // Per-frame result latch; box is zeroed when the object is too small
  always_ff @(posedge pixelclk) begin
    if (reset) begin
      o_xmin    <= '0;
      o_xmax    <= '0;
      o_ymin    <= '0;
      o_ymax    <= '0;
      o_pix_cnt <= '0;
      o_found   <= 1'b0;
      o_valid   <= 1'b0;
    end else begin
      o_valid <= latch_c;
      if (latch_c) begin
        o_pix_cnt <= acc_cnt;
        if (acc_cnt >= MIN_CNT) begin
          o_found <= 1'b1;
          o_xmin  <= acc_xmin;
          o_xmax  <= acc_xmax;
          o_ymin  <= acc_ymin;
          o_ymax  <= acc_ymax;
        end else begin
          o_found <= 1'b0;
          o_xmin  <= '0;
          o_xmax  <= '0;
          o_ymin  <= '0;
          o_ymax  <= '0;
        end
      end
    end
  end

  // Outline test on active pixels only; blanking keeps the source colour
  always_comb begin
    on_box_c = 1'b0;
    if (o_found && i_de &&
        x_cnt >= o_xmin && x_cnt <= o_xmax &&
        y_cnt >= o_ymin && y_cnt <= o_ymax &&
        (x_cnt == o_xmin || x_cnt == o_xmax ||
         y_cnt == o_ymin || y_cnt == o_ymax)) begin
      on_box_c = 1'b1;
    end
  end

  // One-clock video path
  always_ff @(posedge pixelclk) begin
    if (reset) begin
      o_rgb   <= '0;
      o_hsync <= 1'b0;
      o_vsync <= 1'b0;
      o_de    <= 1'b0;
    end else begin
      o_rgb   <= on_box_c ? BOX_RGB : i_rgb;
      o_hsync <= i_hsync;
      o_vsync <= i_vsync;
      o_de    <= i_de;
    end
  end

endmodule

// File: tb/tb_binary_bbox_overlay.sv
// Frame-level bench for binary_bbox_overlay: per-cycle expectations queued at
// drive time from the generator's own pixel coordinates, compared on output.
module tb_binary_bbox_overlay;

  localparam int unsigned   DW      = 24;
  localparam int unsigned   XW      = 12;
  localparam int unsigned   CW      = 20;
  localparam int unsigned   MIN_PIX = 64;
  localparam logic [DW-1:0] BOX     = 24'hFF0000;

  logic          pixelclk = 1'b0;
  logic          reset;
  logic          i_x0, i_hsync, i_vsync, i_de;
  logic [DW-1:0] i_rgb;
  logic [DW-1:0] o_rgb;
  logic          o_hsync, o_vsync, o_de;
  logic [XW-1:0] o_xmin, o_xmax, o_ymin, o_ymax;
  logic [CW-1:0] o_pix_cnt;
  logic          o_found, o_valid;

  binary_bbox_overlay #(
    .DW(DW), .XW(XW), .CW(CW), .MIN_PIX(MIN_PIX), .BOX_RGB(BOX)
  ) dut (
    .pixelclk(pixelclk), .reset(reset), .i_x0(i_x0), .i_rgb(i_rgb),
    .i_hsync(i_hsync), .i_vsync(i_vsync), .i_de(i_de),
    .o_rgb(o_rgb), .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de),
    .o_xmin(o_xmin), .o_xmax(o_xmax), .o_ymin(o_ymin), .o_ymax(o_ymax),
    .o_pix_cnt(o_pix_cnt), .o_found(o_found), .o_valid(o_valid)
  );

  always #5 pixelclk = ~pixelclk;

  typedef struct packed {
    logic          valid;
    logic          found;
    logic [XW-1:0] xmin, xmax, ymin, ymax;
    logic [CW-1:0] cnt;
    logic [DW-1:0] rgb;
    logic          hs, vs, de;
  } obs_t;

  obs_t exp_q[$];
  obs_t act_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Frame-level reference state
  bit started, prev_vs;
  int m_xmin, m_xmax, m_ymin, m_ymax, m_cnt;
  bit l_found;
  int l_xmin, l_xmax, l_ymin, l_ymax, l_cnt;

  function automatic void model_clear();
    m_xmin = 4095; m_xmax = 0; m_ymin = 4095; m_ymax = 0; m_cnt = 0;
  endfunction

  // One clock: queue the expected output, drive the inputs, capture the outputs
  task automatic drive_cycle(input bit rst, input bit x0, input logic [DW-1:0] rgb,
                             input bit hs, input bit vs, input bit de,
                             input int ex, input int ey);
    obs_t e, a;
    bit   vsr;
    e = '0;
    if (rst) begin
      started = 0; prev_vs = 0; model_clear();
      l_found = 0; l_xmin = 0; l_xmax = 0; l_ymin = 0; l_ymax = 0; l_cnt = 0;
    end else begin
      vsr = vs && !prev_vs;
      e.rgb = (de && l_found && ex >= l_xmin && ex <= l_xmax && ey >= l_ymin && ey <= l_ymax &&
               (ex == l_xmin || ex == l_xmax || ey == l_ymin || ey == l_ymax)) ? BOX : rgb;
      e.hs = hs; e.vs = vs; e.de = de;
      if (vsr) begin
        if (started) begin
          e.valid = 1'b1;
          l_cnt   = m_cnt;
          l_found = (m_cnt >= int'(MIN_PIX));
          l_xmin  = l_found ? m_xmin : 0;
          l_xmax  = l_found ? m_xmax : 0;
          l_ymin  = l_found ? m_ymin : 0;
          l_ymax  = l_found ? m_ymax : 0;
        end
        started = 1;
        model_clear();
      end else if (started && de && x0) begin
        if (ex < m_xmin) m_xmin = ex;
        if (ex > m_xmax) m_xmax = ex;
        if (ey < m_ymin) m_ymin = ey;
        if (ey > m_ymax) m_ymax = ey;
        m_cnt++;
      end
      prev_vs = vs;
      e.found = l_found;
      e.xmin = XW'(l_xmin); e.xmax = XW'(l_xmax);
      e.ymin = XW'(l_ymin); e.ymax = XW'(l_ymax);
      e.cnt  = CW'(l_cnt);
    end
    exp_q.push_back(e);
    reset = rst; i_x0 = x0; i_rgb = rgb; i_hsync = hs; i_vsync = vs; i_de = de;
    @(posedge pixelclk);
    #1;
    a.valid = o_valid; a.found = o_found;
    a.xmin = o_xmin; a.xmax = o_xmax; a.ymin = o_ymin; a.ymax = o_ymax;
    a.cnt = o_pix_cnt; a.rgb = o_rgb; a.hs = o_hsync; a.vs = o_vsync; a.de = o_de;
    act_q.push_back(a);
  endtask

  // mode 0: empty, 1: rectangle [sx0..sx1]x[sy0..sy1], 2: random with dens percent
  task automatic send_frame(input int w, input int h, input int mode,
                            input int sx0, input int sx1, input int sy0, input int sy1,
                            input int dens, input bit vs_de, input int rst_at);
    int cyc;
    bit fg;
    cyc = 0;
    drive_cycle(cyc == rst_at, vs_de, {8'h00, 16'($urandom)}, 1'b0, 1'b1, vs_de, 0, 0); cyc++;
    drive_cycle(cyc == rst_at, 1'b0, {8'h00, 16'($urandom)}, 1'b0, 1'b1, 1'b0, 0, 0); cyc++;
    repeat (2) begin
      drive_cycle(cyc == rst_at, 1'b0, {8'h00, 16'($urandom)}, 1'b0, 1'b0, 1'b0, 0, 0); cyc++;
    end
    for (int r = 0; r < h; r++) begin
      for (int k = 0; k < 3; k++) begin
        drive_cycle(cyc == rst_at, 1'b0, {8'h00, 16'($urandom)}, k < 2, 1'b0, 1'b0, 0, 0); cyc++;
      end
      for (int c = 0; c < w; c++) begin
        case (mode)
          1:       fg = (c >= sx0 && c <= sx1 && r >= sy0 && r <= sy1);
          2:       fg = ($urandom_range(99) < dens);
          default: fg = 1'b0;
        endcase
        drive_cycle(cyc == rst_at, fg, {8'h00, 16'($urandom)}, 1'b0, 1'b0, 1'b1, c, r); cyc++;
      end
    end
    repeat (2) begin
      drive_cycle(cyc == rst_at, 1'b0, {8'h00, 16'($urandom)}, 1'b0, 1'b0, 1'b0, 0, 0); cyc++;
    end
  endtask

  task automatic test_reset();
    obs_t e, a;
    repeat (3) drive_cycle(1'b1, 1'b1, 24'h123456, 1'b1, 1'b1, 1'b1, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL reset_state got=%h want=%h", a, e); end
    end
  endtask

  task automatic test_empty_frames();
    obs_t e, a;
    int   nv;
    nv = 0;
    repeat (3) send_frame(16, 8, 0, 0, 0, 0, 0, 0, 1'b0, -1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL empty_frames got=%h want=%h", a, e); end
      if (a.valid) nv++;
    end
    n_checks++;
    if (nv !== 2) begin n_fail++; $display("FAIL empty_valid_pulses got=%0d want=2", nv); end
  endtask

  task automatic test_square_found();
    obs_t e, a;
    int   nbox;
    nbox = 0;
    for (int f = 0; f < 2; f++) begin
      send_frame(16, 14, (f == 0) ? 1 : 0, 3, 12, 2, 11, 0, 1'b0, -1);
      if (f == 1) begin
        n_checks++;
        if ({o_found, o_pix_cnt, o_xmin, o_xmax, o_ymin, o_ymax} !==
            {1'b1, CW'(100), XW'(3), XW'(12), XW'(2), XW'(11)}) begin
          n_fail++;
          $display("FAIL square_latch got found=%b cnt=%0d box=(%0d,%0d,%0d,%0d) want 1 100 (3,12,2,11)",
                   o_found, o_pix_cnt, o_xmin, o_xmax, o_ymin, o_ymax);
        end
      end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); a = act_q.pop_front();
        n_checks++;
        if (a !== e) begin n_fail++; $display("FAIL square_stream got=%h want=%h", a, e); end
        if (f == 1 && a.de && a.rgb === BOX) nbox++;
      end
    end
    n_checks++;
    if (nbox !== 36) begin n_fail++; $display("FAIL square_border_pixels got=%0d want=36", nbox); end
  endtask

  task automatic test_square_small();
    obs_t e, a;
    int   nbox;
    nbox = 0;
    for (int f = 0; f < 2; f++) begin
      send_frame(16, 14, (f == 0) ? 1 : 0, 3, 7, 2, 6, 0, 1'b0, -1);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); a = act_q.pop_front();
        n_checks++;
        if (a !== e) begin n_fail++; $display("FAIL small_stream got=%h want=%h", a, e); end
        if (f == 1 && a.de && a.rgb === BOX) nbox++;
      end
    end
    n_checks++;
    if ({o_found, o_pix_cnt, o_xmin, o_xmax, o_ymin, o_ymax} !== {1'b0, CW'(25), 48'd0}) begin
      n_fail++;
      $display("FAIL small_latch got found=%b cnt=%0d box=(%0d,%0d,%0d,%0d) want 0 25 (0,0,0,0)",
               o_found, o_pix_cnt, o_xmin, o_xmax, o_ymin, o_ymax);
    end
    n_checks++;
    if (nbox !== 0) begin n_fail++; $display("FAIL small_overlay_pixels got=%0d want=0", nbox); end
  endtask

  task automatic test_vsync_pixel();
    obs_t e, a;
    send_frame(16, 8, 1, 0, 4, 0, 0, 0, 1'b0, -1);
    send_frame(16, 8, 1, 0, 2, 1, 1, 0, 1'b1, -1);
    n_checks++;
    if (o_pix_cnt !== CW'(5)) begin n_fail++; $display("FAIL vs_pixel_frame_a got=%0d want=5", o_pix_cnt); end
    send_frame(16, 8, 0, 0, 0, 0, 0, 0, 1'b0, -1);
    n_checks++;
    if (o_pix_cnt !== CW'(3)) begin n_fail++; $display("FAIL vs_pixel_frame_b got=%0d want=3", o_pix_cnt); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL vs_pixel_stream got=%h want=%h", a, e); end
    end
  endtask

  task automatic test_reset_midframe();
    obs_t e, a;
    int   nv;
    // cycle 107 lands on column 5 of row 5, inside the foreground square
    send_frame(16, 14, 1, 3, 12, 2, 11, 0, 1'b0, 107);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL midreset_stream got=%h want=%h", a, e); end
    end
    for (int f = 0; f < 2; f++) begin
      nv = 0;
      send_frame(16, 8, 0, 0, 0, 0, 0, 0, 1'b0, -1);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); a = act_q.pop_front();
        n_checks++;
        if (a !== e) begin n_fail++; $display("FAIL midreset_after got=%h want=%h", a, e); end
        if (a.valid) nv++;
      end
      n_checks++;
      if (nv !== f) begin n_fail++; $display("FAIL midreset_valid frame=%0d got=%0d want=%0d", f, nv, f); end
    end
  endtask

  task automatic test_random_frames();
    obs_t e, a;
    int   nv, dens;
    nv = 0;
    for (int f = 0; f < 21; f++) begin
      case (f % 3)
        0:       dens = 10;
        1:       dens = 50;
        default: dens = 85;
      endcase
      send_frame(16, 12, (f < 20) ? 2 : 0, 0, 0, 0, 0, dens, 1'b0, -1);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); a = act_q.pop_front();
        n_checks++;
        if (a !== e) begin n_fail++; $display("FAIL random_frame %0d got=%h want=%h", f, a, e); end
        if (a.valid) nv++;
      end
    end
    n_checks++;
    if (nv !== 21) begin n_fail++; $display("FAIL random_valid_pulses got=%0d want=21", nv); end
  endtask

  initial begin
    reset = 1'b1; i_x0 = 1'b0; i_rgb = '0; i_hsync = 1'b0; i_vsync = 1'b0; i_de = 1'b0;
    model_clear();
    test_reset();
    test_empty_frames();
    test_square_found();
    test_square_small();
    test_vsync_pixel();
    test_reset_midframe();
    test_random_frames();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/binary_bbox_overlay.md
BINARY_BBOX_OVERLAY -- requirements
Module: binary_bbox_overlay

Interface
REQ-001 Parameters: DW, default 24, pixel width. XW, default 12, coordinate width. CW, default 20, pixel-count width. MIN_PIX, default 64, minimum foreground count for a valid object. BOX_RGB, default 24'hFF0000, rectangle colour.
REQ-002 pixelclk  input  1  pixel clock; every register SHALL be clocked on its rising edge.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 i_x0  input  1  binary mask from the threshold stage; 1 = foreground, 0 = background.
REQ-005 i_rgb  input  DW  original pixel, aligned with i_x0.
REQ-006 i_hsync, i_vsync, i_de  input  1 each  video timing aligned with i_x0; i_vsync is active-high.
REQ-007 o_rgb  output  DW  pixel with rectangle overlay.
REQ-008 o_hsync, o_vsync, o_de  output  1 each  timing delayed to match o_rgb.
REQ-009 o_xmin, o_xmax, o_ymin, o_ymax  output  XW each  latched bounding box of the previous complete frame.
REQ-010 o_pix_cnt  output  CW  foreground count of the previous complete frame.
REQ-011 o_found  output  1  latched box is valid (count >= MIN_PIX).
REQ-012 o_valid  output  1  one-cycle pulse when the box outputs update.

Function
REQ-013 Video path latency SHALL be exactly 1 clock: o_hsync, o_vsync and o_de are i_hsync, i_vsync and i_de registered once.
REQ-014 Frame boundary SHALL be the rising edge of i_vsync (vs_rise = i_vsync & ~i_vsync_d1).
REQ-015 x_cnt: incremented on every cycle with i_de=1; cleared to 0 on the cycle after i_de falls; x of the current pixel = x_cnt before increment, starting at 0.
REQ-016 y_cnt: incremented on each i_de falling edge; cleared to 0 on vs_rise; first active line is y=0.
REQ-017 Counters SHALL saturate at 2^XW-1 and SHALL NOT wrap.
REQ-018 FSM states: IDLE, ACCUM. Reset enters IDLE. IDLE -> ACCUM on first vs_rise, with no latch. ACCUM -> ACCUM on every vs_rise, with latch and accumulator clear.
REQ-019 In ACCUM, each cycle with i_de=1 and i_x0=1 SHALL update: xmin=min, xmax=max, ymin=min, ymax=max; cnt+1, saturating at 2^CW-1.
REQ-020 Accumulator clear values: xmin=ymin=all-ones, xmax=ymax=0, cnt=0.
REQ-021 Latch on vs_rise in ACCUM: o_pix_cnt=cnt. If cnt>=MIN_PIX: o_found=1 and the box outputs take the accumulated min/max. Otherwise: o_found=0 and all box outputs are set to 0. o_valid=1 for exactly that cycle.
REQ-022 A cycle with vs_rise and i_de=1 together: vs_rise has priority; that pixel SHALL NOT be accumulated into either frame.
REQ-023 In IDLE no accumulation occurs; the partial frame after reset is discarded.
REQ-024 Overlay uses the latched outputs. If o_found=1 and the pixel has x in [o_xmin,o_xmax] and y in [o_ymin,o_ymax], with x equal to o_xmin or o_xmax, or y equal to o_ymin or o_ymax, then o_rgb=BOX_RGB. Otherwise o_rgb=i_rgb delayed 1 clock.
REQ-025 A latch occurring mid-frame SHALL affect the overlay from the next cycle onward; this requires no special handling because the latch happens at vsync.
REQ-026 A single-pixel object (xmin=xmax, ymin=ymax) SHALL draw one BOX_RGB pixel.

Reset
REQ-027 While reset=1 on a clock edge, the following SHALL all be 0 on the next edge: o_rgb, o_hsync, o_vsync, o_de, o_xmin, o_xmax, o_ymin, o_ymax, o_pix_cnt, o_found, o_valid.
REQ-028 While reset=1, accumulators SHALL take their clear values, counters SHALL be 0, and the FSM SHALL be in IDLE.
REQ-029 Reset asserted mid-frame SHALL discard the frame in progress; after release, no o_valid until two vs_rise events have occurred.

Verification
REQ-030 Reset release, 16x8 frame with all i_x0=0, three vsyncs -> first vsync: no o_valid; second and third: o_valid pulse, o_found=0, o_pix_cnt=0, box=0.
REQ-031 10x10 foreground square at x=3..12, y=2..11, MIN_PIX=64 -> o_pix_cnt=100, o_found=1, box (3,12,2,11); next frame o_rgb=BOX_RGB only on the border pixels, 36 pixels total.
REQ-032 Same square but 5x5 (25 pixels) -> o_found=0, box=0, o_pix_cnt=25, no overlay pixels.
REQ-033 Pixel with i_x0=1 arriving on the same cycle as vs_rise -> excluded; counts of both frames are unchanged by it.
REQ-034 Reset pulsed mid-frame with foreground present -> all outputs 0 next cycle; the first o_valid appears only at the second subsequent vsync.
REQ-035 Random mask vs. reference model over 20 frames -> o_hsync, o_vsync, o_de equal the inputs delayed 1 clock; box and count match the model every frame.
